imem_port_arb: RTL and testbench

Two-master arbiter that shares a single req/gnt/rvalid memory port between the instruction fetch unit and the data load/store path. Data requests have fixed priority. A starvation counter guarantees forward progress for instruction fetch. Accepted transactions are tracked in an in-order ID FIFO so that each `mem_rvalid_i` is routed back to the master that issued it. The block sits between the core (ifu / lsu) and the shared memory or bus slave port.

---
 rtl/imem_port_arb.sv | 129 ++++++++++++
 tb/tb_imem_port_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imem_port_arb.sv
// Fixed-priority two-master arbiter sharing one req/gnt/rvalid memory port between
// instruction fetch and data load/store, with a fetch starvation guard and in-order response routing.
module imem_port_arb #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        resp_orphan_o
);
    localparam logic [2:0] CNT_MAX    = 3'(OUTSTANDING);
    localparam logic [1:0] PTR_LAST   = 2'(OUTSTANDING - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] fifo_q, fifo_d;
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] starve_q, starve_d;
    logic       orphan_q, orphan_d;
    logic       full_s, empty_s, starved_s;
    logic       instr_sel_s, data_sel_s, push_s, pop_s, head_s;

    // Arbitration, request mux and response routing (all zero-latency paths)
    always_comb begin
        full_s      = (cnt_q == CNT_MAX);
        empty_s     = (cnt_q == 3'd0);
        starved_s   = (starve_q == STARVE_MAX);
        instr_sel_s = instr_req_i & (starved_s | ~data_req_i);
        data_sel_s  = data_req_i & ~instr_sel_s;
        // full blocks requests even when a pop frees a slot this same cycle
        mem_req_o   = (instr_req_i | data_req_i) & ~full_s;
        if (instr_sel_s) begin
            mem_addr_o  = instr_addr_i;
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_wdata_o = 32'h0;
        end else begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
        instr_gnt_o    = mem_gnt_i & ~full_s & instr_sel_s;
        data_gnt_o     = mem_gnt_i & ~full_s & data_sel_s;
        push_s         = instr_gnt_o | data_gnt_o;
        pop_s          = mem_rvalid_i & ~empty_s;
        head_s         = fifo_q[rptr_q];
        instr_rvalid_o = pop_s & ~head_s;
        data_rvalid_o  = pop_s & head_s;
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
        instr_err_o    = instr_rvalid_o & mem_err_i;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
        data_err_o     = data_rvalid_o & mem_err_i;
        resp_orphan_o  = orphan_q;
    end

    // Next-state for ID FIFO, starvation counter and orphan flag
    always_comb begin
        fifo_d = fifo_q;
        if (push_s) begin
            fifo_d[wptr_q] = data_gnt_o;
            wptr_d         = (wptr_q == PTR_LAST) ? 2'd0 : wptr_q + 2'd1;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = (rptr_q == PTR_LAST) ? 2'd0 : rptr_q + 2'd1;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
        if (instr_gnt_o | ~instr_req_i) begin
            starve_d = 4'd0;
        end else if (data_gnt_o && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
        orphan_d = orphan_q | (mem_rvalid_i & empty_s);
    end

    // State registers; reset drops all outstanding tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q   <= 4'h0;
            wptr_q   <= 2'd0;
            rptr_q   <= 2'd0;
            cnt_q    <= 3'd0;
            starve_q <= 4'd0;
            orphan_q <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            orphan_q <= orphan_d;
        end
    end
endmodule

// File: tb/tb_imem_port_arb.sv
// Directed bench for imem_port_arb: per-cycle vector table plus hand sequences for
// starvation rotation and reset with transactions in flight.
module tb_imem_port_arb;
    localparam logic [31:0] IA = 32'h0000_0080;
    localparam logic [31:0] DA = 32'h0000_0100;
    localparam logic [31:0] DW = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq, dreq, dwe, gnt, rv, err;
    logic [3:0]  dbe;
    logic [31:0] rdata;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o, resp_orphan_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int passed = 0;
    int total  = 0;

    imem_port_arb #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(ireq), .instr_addr_i(IA),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe),
        .data_addr_i(DA), .data_wdata_i(DW),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(gnt), .mem_rvalid_i(rv), .mem_rdata_i(rdata), .mem_err_i(err),
        .resp_orphan_o(resp_orphan_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ireq, dreq, dwe; logic [3:0] dbe; logic gnt, rv; logic [31:0] rdata; logic err;
        logic e_req, e_igt, e_dgt, e_irv, e_drv; logic [31:0] e_addr; logic e_we; logic [3:0] e_be;
        logic [31:0] e_ird, e_drd; logic e_ierr, e_derr, e_orph;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input logic a_ir, a_dr, a_we, input logic [3:0] a_be, input logic a_g, a_rv,
                       input logic [31:0] a_rd, input logic a_er,
                       input logic x_req, x_igt, x_dgt, x_irv, x_drv, input logic [31:0] x_addr,
                       input logic x_we, input logic [3:0] x_be, input logic [31:0] x_ird, x_drd,
                       input logic x_ierr, x_derr, x_orph);
        vec_t v;
        v = '{a_ir, a_dr, a_we, a_be, a_g, a_rv, a_rd, a_er,
              x_req, x_igt, x_dgt, x_irv, x_drv, x_addr, x_we, x_be, x_ird, x_drd, x_ierr, x_derr, x_orph};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic a_ir, a_dr, a_g, a_rv, input logic [31:0] a_rd);
        ireq = a_ir; dreq = a_dr; dwe = 1'b0; dbe = 4'hF; gnt = a_g; rv = a_rv; rdata = a_rd; err = 1'b0;
    endtask

    initial begin
        logic exp_i, exp_r;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req_o, 32'd0);
        check("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 32'd0);
        check("rst_orphan", resp_orphan_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //   ireq dreq we be    gnt rv rdata         err | req igt dgt irv drv addr we be    ird           drd           ie de orph
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  1, 1, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 1, 32'h13,        0,  1, 1, 0, 1, 0, IA, 0, 4'hF, 32'h13,       32'h0,        0, 0, 0);
        add(0, 0, 0, 4'h0, 1, 1, 32'h13,        0,  0, 0, 0, 1, 0, IA, 0, 4'hF, 32'h13,       32'h0,        0, 0, 0);
        add(0, 1, 1, 4'h3, 1, 0, 32'h0,         0,  1, 0, 1, 0, 0, DA, 1, 4'h3, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  1, 1, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  0, 0, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 1, 32'h0000_D00D, 0,  0, 0, 0, 0, 1, IA, 0, 4'hF, 32'h0,        32'h0000_D00D, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 1, 32'h0000_1234, 1,  0, 0, 0, 1, 0, IA, 0, 4'hF, 32'h0000_1234, 32'h0,       1, 0, 0);
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  1, 1, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  1, 1, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  0, 0, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 1, 32'h55,        0,  0, 0, 0, 1, 0, IA, 0, 4'hF, 32'h55,       32'h0,        0, 0, 0);
        add(1, 0, 0, 4'h0, 1, 0, 32'h0,         0,  1, 1, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 1, 32'h66,        0,  0, 0, 0, 1, 0, IA, 0, 4'hF, 32'h66,       32'h0,        0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 1, 32'h77,        0,  0, 0, 0, 1, 0, IA, 0, 4'hF, 32'h77,       32'h0,        0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 1, 32'h99,        1,  0, 0, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 32'h0,         0,  0, 0, 0, 0, 0, IA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 1);
        add(1, 1, 0, 4'hF, 0, 0, 32'h0,         0,  1, 0, 0, 0, 0, DA, 0, 4'hF, 32'h0,        32'h0,        0, 0, 1);
        add(0, 1, 0, 4'h5, 1, 0, 32'h0,         0,  1, 0, 1, 0, 0, DA, 0, 4'h5, 32'h0,        32'h0,        0, 0, 1);
        add(0, 0, 0, 4'h0, 0, 1, 32'hAA,        1,  0, 0, 0, 0, 1, IA, 0, 4'hF, 32'h0,        32'hAA,       0, 1, 1);

        foreach (vecs[k]) begin
            ireq = vecs[k].ireq; dreq = vecs[k].dreq; dwe = vecs[k].dwe; dbe = vecs[k].dbe;
            gnt = vecs[k].gnt; rv = vecs[k].rv; rdata = vecs[k].rdata; err = vecs[k].err;
            @(negedge clk);
            check($sformatf("v%0d_req", k), mem_req_o, vecs[k].e_req);
            check($sformatf("v%0d_igt", k), instr_gnt_o, vecs[k].e_igt);
            check($sformatf("v%0d_dgt", k), data_gnt_o, vecs[k].e_dgt);
            check($sformatf("v%0d_irv", k), instr_rvalid_o, vecs[k].e_irv);
            check($sformatf("v%0d_drv", k), data_rvalid_o, vecs[k].e_drv);
            check($sformatf("v%0d_ird", k), instr_rdata_o, vecs[k].e_ird);
            check($sformatf("v%0d_drd", k), data_rdata_o, vecs[k].e_drd);
            check($sformatf("v%0d_err", k), {instr_err_o, data_err_o}, {vecs[k].e_ierr, vecs[k].e_derr});
            check($sformatf("v%0d_orph", k), resp_orphan_o, vecs[k].e_orph);
            if (vecs[k].e_req) begin
                check($sformatf("v%0d_addr", k), mem_addr_o, vecs[k].e_addr);
                check($sformatf("v%0d_we", k), mem_we_o, vecs[k].e_we);
                check($sformatf("v%0d_be", k), mem_be_o, vecs[k].e_be);
                check($sformatf("v%0d_wdata", k), mem_wdata_o, (vecs[k].e_addr == DA) ? DW : 32'h0);
            end
            @(posedge clk); #1;
        end

        // Both masters requesting continuously against a 1-cycle memory: D D D D I repeating
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 1'b1, (i > 0), 32'h1000 + 32'(i));
            @(negedge clk);
            exp_i = ((i % 5) == 4);
            check($sformatf("stv%0d_igt", i), instr_gnt_o, exp_i);
            check($sformatf("stv%0d_dgt", i), data_gnt_o, !exp_i);
            if (i > 0) begin
                exp_r = (((i - 1) % 5) == 4);
                check($sformatf("stv%0d_irv", i), instr_rvalid_o, exp_r);
                check($sformatf("stv%0d_drv", i), data_rvalid_o, !exp_r);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h2000);
        @(negedge clk);
        check("stv_drain_irv", instr_rvalid_o, 32'd1);
        check("stv_drain_rdata", instr_rdata_o, 32'h2000);
        check("orphan_sticky", resp_orphan_o, 32'd1);
        @(posedge clk); #1;

        // Two transactions in flight, then reset
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("pre_rst_dgt", data_gnt_o, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h77);
        rst_n = 1'b0;
        #1;
        check("in_rst_req", mem_req_o, 32'd0);
        check("in_rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 32'd0);
        check("in_rst_rdata", instr_rdata_o | data_rdata_o, 32'd0);
        check("in_rst_orphan", resp_orphan_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = 1'b0;
        @(posedge clk); #1;
        rv = 1'b1;
        @(negedge clk);
        check("post_rst_stray_rv", {instr_rvalid_o, data_rvalid_o}, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("post_rst_orphan", resp_orphan_o, 32'd1);
        check("post_rst_igt", instr_gnt_o, 32'd1);
        check("post_rst_req", mem_req_o, 32'd1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
